pipelined_add_sub: RTL

- Parametrised, pipelined WIDTH-bit adder/subtractor.
- Splits the operands into CHUNK-bit slices; one slice is resolved per pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on both sides; sustains one operation per cycle.
- Successor to the fixed 8-bit ripple adder; used wherever wide arithmetic must meet timing at the system clock.

---
 rtl/pipelined_add_sub_pkg.sv | 30 +++
 rtl/pipelined_add_sub_add_chunk.sv | 35 +++
 rtl/pipelined_add_sub.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined add/sub datapath and its sibling
// pipelined arithmetic blocks.
//   - default operand width and slice width, and the derived stage count
//   - slice index helper
//   - handshake advance-enable expression used by every stall-together pipeline
package pipelined_add_sub_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultChunk = 8;

    // Number of pipeline stages: one slice resolved per stage.
    function automatic int unsigned calc_stages(input int unsigned width,
                                                input int unsigned chunk);
        return width / chunk;
    endfunction

    localparam int unsigned DefaultStages = calc_stages(DefaultWidth, DefaultChunk);

    // LSB position of slice idx.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned chunk);
        return idx * chunk;
    endfunction

    // The whole pipeline advances unless the output stage holds a result that
    // downstream is refusing.
    function automatic logic pipe_advance(input logic out_valid, input logic out_ready);
        return !out_valid || out_ready;
    endfunction

endpackage

// File: rtl/pipelined_add_sub_add_chunk.sv
// Combinational CHUNK-bit ripple adder made of one-bit full-adder cells.
// Ports:
//   a_i, b_i  slice operands
//   cin_i     carry into bit 0
//   sum_o     slice sum
//   cout_o    carry out of the top bit
//   cmsb_o    carry into the top bit (used for signed overflow)
module add_chunk
    import pipelined_add_sub_pkg::*;
#(
    parameter int unsigned CHUNK = DefaultChunk
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[CHUNK];
        cmsb_o = carry[CHUNK-1];
    end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage with the
// carry registered between stages. Lower result slices travel down a de-skew
// path so the full result emerges aligned after STAGES cycles.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready = pipeline advance enable)
//   a, b, c_in, sub      operands; sub=1 computes a + ~b + 1 and ignores c_in
//   out_valid/out_ready  result handshake
//   sum, c_out, overflow result mod 2^WIDTH, MSB carry out, signed overflow
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CHUNK = DefaultChunk
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("pipelined_add_sub: WIDTH must be a multiple of CHUNK");
    end

    logic en;
    assign en       = pipe_advance(out_valid, out_ready);
    assign in_ready = en;

    // Bubbles enter with all-zero data so idle stages stay at zero.
    logic [WIDTH-1:0] a_in, b_in;
    logic             cin_in;
    always_comb begin
        a_in   = in_valid ? a : '0;
        b_in   = in_valid ? (sub ? ~b : b) : '0;
        cin_in = in_valid & (sub | c_in);
    end

    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic             cmsb_q  [STAGES];
    logic             cmsb_d  [STAGES];

    logic [CHUNK-1:0] chunk_a    [STAGES];
    logic [CHUNK-1:0] chunk_b    [STAGES];
    logic [CHUNK-1:0] chunk_sum  [STAGES];
    logic             chunk_cin  [STAGES];
    logic             chunk_cout [STAGES];
    logic             chunk_cmsb [STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign chunk_a[g]   = a_in[CHUNK-1:0];
            assign chunk_b[g]   = b_in[CHUNK-1:0];
            assign chunk_cin[g] = cin_in;
        end else begin : g_rest
            assign chunk_a[g]   = a_q[g-1][slice_lo(g, CHUNK) +: CHUNK];
            assign chunk_b[g]   = b_q[g-1][slice_lo(g, CHUNK) +: CHUNK];
            assign chunk_cin[g] = carry_q[g-1];
        end

        add_chunk #(
            .CHUNK (CHUNK)
        ) u_add_chunk (
            .a_i    (chunk_a[g]),
            .b_i    (chunk_b[g]),
            .cin_i  (chunk_cin[g]),
            .sum_o  (chunk_sum[g]),
            .cout_o (chunk_cout[g]),
            .cmsb_o (chunk_cmsb[g])
        );
    end

    always_comb begin
        for (int unsigned s = 0; s < STAGES; s++) begin
            valid_d[s] = valid_q[s];
            a_d[s]     = a_q[s];
            b_d[s]     = b_q[s];
            sum_d[s]   = sum_q[s];
            carry_d[s] = carry_q[s];
            cmsb_d[s]  = cmsb_q[s];
        end
        if (en) begin
            valid_d[0]            = in_valid;
            a_d[0]                = a_in;
            b_d[0]                = b_in;
            sum_d[0]              = '0;
            sum_d[0][CHUNK-1:0]   = chunk_sum[0];
            carry_d[0]            = chunk_cout[0];
            cmsb_d[0]             = chunk_cmsb[0];
            for (int unsigned k = 1; k < STAGES; k++) begin
                valid_d[k]                    = valid_q[k-1];
                a_d[k]                        = a_q[k-1];
                b_d[k]                        = b_q[k-1];
                // Carry lower slices forward and insert this stage's slice.
                sum_d[k]                      = sum_q[k-1];
                sum_d[k][k * CHUNK +: CHUNK]  = chunk_sum[k];
                carry_d[k]                    = chunk_cout[k];
                cmsb_d[k]                     = chunk_cmsb[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                a_q[s]     <= '0;
                b_q[s]     <= '0;
                sum_q[s]   <= '0;
                carry_q[s] <= 1'b0;
                cmsb_q[s]  <= 1'b0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                valid_q[s] <= valid_d[s];
                a_q[s]     <= a_d[s];
                b_q[s]     <= b_d[s];
                sum_q[s]   <= sum_d[s];
                carry_q[s] <= carry_d[s];
                cmsb_q[s]  <= cmsb_d[s];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign c_out     = carry_q[STAGES-1];
    assign overflow  = cmsb_q[STAGES-1] ^ carry_q[STAGES-1];

endmodule
